// File: rtl/fb_rect_writer_if.sv
// Rectangle-fill command channel: valid/ready handshake plus the
// latched geometry and colour index of one fill request.
interface fb_rect_writer_if #(
    parameter int IDX_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [9:0]       cmd_x;
    logic [8:0]       cmd_y;
    logic [9:0]       cmd_w;
    logic [8:0]       cmd_h;
    logic [IDX_W-1:0] cmd_index;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_index,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_index,
        output cmd_ready
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Framebuffer rectangle-fill engine: clips a command to the visible
// area and emits one linear-addressed pixel write per clock.
module fb_rect_writer #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ADDR_W      = 19,
    parameter int IDX_W       = 8,
    parameter bit SYNC_VBLANK = 1'b1
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    fb_rect_writer_if.slave   cmd,
    input  logic              iVBLANK,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [IDX_W-1:0]  wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              clipped
);
    typedef enum logic [1:0] {
        IDLE, WAIT_VB, DRAW, DONE
    } state_e;

    localparam logic [10:0]       HR     = 11'(H_RES);
    localparam logic [9:0]        VR     = 10'(V_RES);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

    state_e              state_q, state_d;
    logic [9:0]          col_q, col_d, xs_q, xs_d;
    logic [8:0]          row_q, row_d;
    logic [10:0]         xe_q, xe_d;
    logic [9:0]          ye_q, ye_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]    data_q, data_d;
    logic                wen_q, wen_d;
    logic                clip_q, clip_d;
    logic                rdy_q, busy_q, done_q;
    logic [10:0]         sx;
    logic [9:0]          sy;
    logic                empty, oob, issue, eol, eor, vb_hold;

    assign sx = {1'b0, cmd.cmd_x} + {1'b0, cmd.cmd_w};
    assign sy = {1'b0, cmd.cmd_y} + {1'b0, cmd.cmd_h};
    assign oob = ({1'b0, cmd.cmd_x} >= HR) || ({1'b0, cmd.cmd_y} >= VR);
    assign empty = oob || (cmd.cmd_w == '0) || (cmd.cmd_h == '0);
    assign vb_hold = SYNC_VBLANK && !iVBLANK;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        base_d  = base_q;
        idx_d   = idx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wen_d   = 1'b0;
        clip_d  = clip_q;
        issue   = 1'b0;
        eol     = 1'b0;
        eor     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    col_d  = cmd.cmd_x;
                    xs_d   = cmd.cmd_x;
                    row_d  = cmd.cmd_y;
                    xe_d   = (sx > HR) ? HR : sx;
                    ye_d   = (sy > VR) ? VR : sy;
                    // constant product: reduces to shift-add
                    base_d = ADDR_W'(cmd.cmd_y) * STRIDE;
                    idx_d  = cmd.cmd_index;
                    clip_d = oob || (sx > HR) || (sy > VR);
                    if (empty) begin
                        state_d = DONE;
                    end else if (vb_hold) begin
                        state_d = WAIT_VB;
                    end else begin
                        state_d = DRAW;
                        issue   = 1'b1;
                    end
                end
            end
            WAIT_VB: begin
                if (iVBLANK) begin
                    state_d = DRAW;
                    issue   = 1'b1;
                end
            end
            DRAW: begin
                if (last_q) begin
                    state_d = DONE;
                end else if (vb_hold) begin
                    state_d = WAIT_VB;
                end else begin
                    issue = 1'b1;
                end
            end
            DONE: state_d = IDLE;
        endcase
        // col/row/base always point at the next pixel to emit
        if (issue) begin
            wen_d  = 1'b1;
            addr_d = base_d + ADDR_W'(col_d);
            data_d = idx_d;
            eol    = ({1'b0, col_d} + 11'd1) == xe_d;
            eor    = ({1'b0, row_d} + 10'd1) == ye_d;
            last_d = eol && eor;
            if (eol) begin
                col_d  = xs_d;
                row_d  = row_d + 9'd1;
                base_d = base_d + STRIDE;
            end else begin
                col_d = col_d + 10'd1;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            xs_q    <= '0;
            row_q   <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            clip_q  <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            xs_q    <= xs_d;
            row_q   <= row_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            clip_q  <= clip_d;
            rdy_q   <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign cmd.cmd_ready = rdy_q;
    assign wr_addr       = addr_q;
    assign wr_data       = data_q;
    assign wr_en         = wen_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign clipped       = clip_q;
endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
Write-side engine for the 640x480 8-bit colour-index framebuffer that the VGA scan-out path reads. It accepts rectangle-fill commands (origin, size, colour index) over a valid/ready handshake and produces one framebuffer write per clock. Writes are linear-addressed: addr = y*H_RES + x. Optionally, writes are gated to vertical blanking so scan-out never shows a half-drawn object. It sits between game/CPU logic (snake, food, clear-screen) and the framebuffer RAM write port.

Parameters:
H_RES, 640, visible pixels per line; row stride of the framebuffer
V_RES, 480, visible lines
ADDR_W, 19, framebuffer address width
IDX_W, 8, colour-index width
SYNC_VBLANK, 1, 1 = write only while iVBLANK=1; 0 = write whenever drawing

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
iRST_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_x  in  10  left column
cmd_y  in  9  top row
cmd_w  in  10  width in pixels
cmd_h  in  9  height in lines
cmd_index  in  IDX_W  colour index to fill
iVBLANK  in  1  high during vertical blanking (from sync generator)
wr_addr  out  ADDR_W  framebuffer write address
wr_data  out  IDX_W  framebuffer write data
wr_en  out  1  write strobe, one pixel per asserted cycle
busy  out  1  command in progress (not IDLE)
done  out  1  one-cycle pulse when a command completes
clipped  out  1  sticky per command: set if the rectangle was clipped or rejected; cleared on next accept

Behaviour:
- Reset is asynchronous on iRST_n low. It forces state=IDLE. All outputs go to 0 except cmd_ready=1. Any in-flight command is abandoned with no further writes and no done pulse.
- States: IDLE, WAIT_VB, DRAW, DONE.
- IDLE: cmd_ready=1. A command is accepted on a cycle with cmd_valid & cmd_ready. At accept, all cmd_* fields are registered; later changes on the inputs are ignored.
- Clipping, applied at accept:
  - x_end = min(cmd_x+cmd_w, H_RES); y_end = min(cmd_y+cmd_h, V_RES). Sums use 11/10-bit arithmetic, so there is no overflow.
  - If cmd_w=0, cmd_h=0, cmd_x>=H_RES or cmd_y>=V_RES: go directly to DONE with zero writes. clipped=1 unless the only cause is w=0 or h=0.
  - clipped=1 whenever x_end or y_end was reduced.
- After a valid accept: go to WAIT_VB if SYNC_VBLANK=1 and iVBLANK=0; otherwise go to DRAW.
- WAIT_VB: wr_en=0. Move to DRAW on the first cycle iVBLANK=1.
- DRAW:
  - Each cycle: wr_en=1, wr_addr=row_base+col, wr_data=registered index.
  - Scan order is row-major: col from cmd_x to x_end-1, then row+1, col=cmd_x.
  - row_base is updated incrementally (+H_RES); no multiplier.
  - On the last pixel (col=x_end-1, row=y_end-1), that write is issued and the next state is DONE.
  - If SYNC_VBLANK=1 and iVBLANK=0 in a DRAW cycle: wr_en=0, position held, return to WAIT_VB. Resume at the same pixel; no pixel is skipped or written twice.
- DONE: done=1 for exactly one cycle, busy=1, cmd_ready=0. Next state is IDLE.
- cmd_ready=0 in WAIT_VB, DRAW and DONE. The earliest next accept is the cycle after DONE.
- Timing: outputs are registered. The first write appears on the cycle after accept, when vblank is already present. A WxH unclipped rectangle without pauses finishes in W*H write cycles plus 1 DONE cycle.
- wr_addr and wr_data are don't-care when wr_en=0 but are held stable.

Test Plan:
- Reset, SYNC_VBLANK=0: accept x=10, y=2, w=3, h=2, index=5 -> six writes on consecutive cycles with addr 1290,1291,1292,1930,1931,1932, all data=5; then done pulse, clipped=0, cmd_ready=1 next cycle.
- Clip: x=638, y=479, w=5, h=4, index=9 -> writes only at 307198 and 307199; clipped=1; done after 2 writes.
- Reject/empty: w=0 -> done one cycle after accept, no wr_en, clipped=0. x=700 -> same timing, clipped=1.
- SYNC_VBLANK=1: accept w=4, h=1 at x=0, y=0 with iVBLANK=0 -> no writes until iVBLANK rises. Drop iVBLANK after 2 writes (addr 0,1) -> wr_en low, stall. Re-raise -> writes addr 2,3 exactly once, then done.
- Handshake: hold cmd_valid high across two commands -> second command accepted only on the cycle after the first done; cmd_x changes mid-draw have no effect.
- Async reset mid-DRAW of a 10x10 fill -> wr_en=0 immediately, no done pulse, cmd_ready=1. A new command after reset executes normally.
